// File: rtl/invaders_pkg.sv
// Shared types, direction encodings and width helpers for the invaders formation block.
package invaders_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StMarch,
        StCleared,
        StLanded
    } state_e;

    localparam logic DirRight = 1'b0;
    localparam logic DirLeft  = 1'b1;

    localparam int unsigned DefaultXW = 5;
    localparam int unsigned DefaultYW = 4;

    function automatic int unsigned alive_w(input int unsigned cells);
        return $clog2(cells + 1);
    endfunction

endpackage

// File: rtl/invaders_formation_extents.sv
// Combinational extents of the alive bitmap: leftmost/rightmost alive column,
// bottom alive row and number of alive invaders.
module invaders_formation_extents #(
    parameter int unsigned COLS  = 10,
    parameter int unsigned ROWS  = 2,
    parameter int unsigned X_W   = 5,
    parameter int unsigned Y_W   = 4,
    parameter int unsigned CNT_W = 5
) (
    input  logic [COLS*ROWS-1:0] array_i,
    output logic [X_W-1:0]       left_col_o,
    output logic [X_W-1:0]       right_col_o,
    output logic [Y_W-1:0]       bottom_row_o,
    output logic [CNT_W-1:0]     popcount_o
);

    logic [COLS-1:0] col_alive;
    logic [ROWS-1:0] row_alive;

    always_comb begin
        col_alive = '0;
        row_alive = '0;
        for (int r = 0; r < ROWS; r++) begin
            for (int c = 0; c < COLS; c++) begin
                if (array_i[r*COLS+c]) begin
                    col_alive[c] = 1'b1;
                    row_alive[r] = 1'b1;
                end
            end
        end
    end

    // Scan from the far side so the last hit wins; all-dead values are don't-care.
    always_comb begin
        left_col_o   = '0;
        right_col_o  = '0;
        bottom_row_o = '0;
        for (int c = COLS - 1; c >= 0; c--) begin
            if (col_alive[c]) left_col_o = X_W'(c);
        end
        for (int c = 0; c < COLS; c++) begin
            if (col_alive[c]) right_col_o = X_W'(c);
        end
        for (int r = 0; r < ROWS; r++) begin
            if (row_alive[r]) bottom_row_o = Y_W'(r);
        end
    end

    always_comb begin
        popcount_o = '0;
        for (int i = 0; i < COLS*ROWS; i++) begin
            popcount_o = popcount_o + CNT_W'(array_i[i]);
        end
    end

endmodule

// File: rtl/invaders_formation.sv
// COLS x ROWS invader formation: march with edge reversal, bullet hits, wave/landing status.
// Optional macro INVADERS_SPEEDUP_EN makes the march period shrink as invaders die.
module invaders_formation
    import invaders_pkg::*;
#(
    parameter int unsigned COLS       = 10,
    parameter int unsigned ROWS       = 2,
    parameter int unsigned X_W        = DefaultXW,
    parameter int unsigned Y_W        = DefaultYW,
    parameter int unsigned FIELD_COLS = 32,
    parameter int unsigned LINE_MAX   = 12,
    parameter int unsigned STEP_BASE  = 360000,
    parameter int unsigned STEP_INC   = 162000
) (
    input  logic                              clk_36MHz,
    input  logic                              reset,
    input  logic                              start,
    input  logic [X_W-1:0]                    bullet_x,
    input  logic [Y_W-1:0]                    bullet_y,
    input  logic                              bullet_flying,
    output logic                              hit,
    output logic [COLS*ROWS-1:0]              invaders_array,
    output logic [Y_W-1:0]                    invaders_line,
    output logic [X_W-1:0]                    invaders_offset,
    output logic [alive_w(COLS*ROWS)-1:0]     alive_count,
    output logic                              wave_clear,
    output logic                              landed,
    output logic [2:0]                        level
);

    localparam int unsigned CELLS       = COLS * ROWS;
    localparam int unsigned CNT_W       = alive_w(CELLS);
    localparam int unsigned IDX_W       = (CELLS > 1) ? $clog2(CELLS) : 1;
    localparam int unsigned RELOAD_FULL = STEP_BASE + CELLS * STEP_INC;
    localparam int unsigned TICK_W      = $clog2(RELOAD_FULL + 1);
    localparam int unsigned LINE_CAP    = LINE_MAX - ROWS;

    state_e             state_q, state_d;
    logic [CELLS-1:0]   array_q, array_d;
    logic [Y_W-1:0]     line_q, line_d;
    logic [X_W-1:0]     offset_q, offset_d;
    logic               dir_q, dir_d;
    logic [TICK_W-1:0]  tick_q, tick_d;
    logic [2:0]         level_q, level_d;
    logic               hit_q, hit_d;
    logic               hit_lock_q, hit_lock_d;
    logic               start_q;

    logic [X_W-1:0]     left_col, right_col;
    logic [Y_W-1:0]     bottom_row;
    logic [CNT_W-1:0]   popcount;
    logic [TICK_W-1:0]  reload;
    logic               start_edge;
    logic [X_W:0]       col_diff;
    logic [Y_W:0]       row_diff;
    logic               in_box;
    logic [IDX_W-1:0]   hit_idx;
    logic               hit_now;
    logic [2:0]         level_next;

    invaders_formation_extents #(
        .COLS  (COLS),
        .ROWS  (ROWS),
        .X_W   (X_W),
        .Y_W   (Y_W),
        .CNT_W (CNT_W)
    ) u_extents (
        .array_i      (array_q),
        .left_col_o   (left_col),
        .right_col_o  (right_col),
        .bottom_row_o (bottom_row),
        .popcount_o   (popcount)
    );

`ifdef INVADERS_SPEEDUP_EN
    assign reload = TICK_W'(STEP_BASE + 32'(popcount) * STEP_INC);
`else
    assign reload = TICK_W'(RELOAD_FULL);
`endif

    assign start_edge = start && !start_q;

    // Extra top bit of each difference is the borrow: bullet left of / above the formation.
    assign col_diff = {1'b0, bullet_x} - {1'b0, offset_q};
    assign row_diff = {1'b0, bullet_y} - {1'b0, line_q};
    assign in_box   = !col_diff[X_W] && !row_diff[Y_W]
                   && (32'(col_diff[X_W-1:0]) < COLS) && (32'(row_diff[Y_W-1:0]) < ROWS);
    assign hit_idx  = IDX_W'(32'(row_diff[Y_W-1:0]) * COLS + 32'(col_diff[X_W-1:0]));
    assign hit_now  = (state_q == StMarch) && bullet_flying && !hit_lock_q && in_box
                   && array_q[hit_idx];

    assign level_next = (level_q == 3'd7) ? level_q : level_q + 3'd1;

    always_comb begin
        state_d    = state_q;
        array_d    = array_q;
        line_d     = line_q;
        offset_d   = offset_q;
        dir_d      = dir_q;
        tick_d     = tick_q;
        level_d    = level_q;
        hit_d      = 1'b0;
        hit_lock_d = bullet_flying ? hit_lock_q : 1'b0;

        unique case (state_q)
            StIdle: begin
                if (start_edge) begin
                    state_d = StMarch;
                    tick_d  = reload;
                end
            end
            StMarch: begin
                if (hit_now) begin
                    array_d[hit_idx] = 1'b0;
                    hit_d            = 1'b1;
                    hit_lock_d       = 1'b1;
                end
                // Step decisions use the pre-hit extents of the registered bitmap.
                if (tick_q == '0) begin
                    tick_d = reload;
                    if (dir_q == DirRight) begin
                        if (32'(offset_q) + 32'(right_col) == FIELD_COLS - 1) begin
                            line_d = line_q + Y_W'(1);
                            dir_d  = DirLeft;
                        end else begin
                            offset_d = offset_q + X_W'(1);
                        end
                    end else begin
                        if (32'(offset_q) + 32'(left_col) == 0) begin
                            line_d = line_q + Y_W'(1);
                            dir_d  = DirRight;
                        end else begin
                            offset_d = offset_q - X_W'(1);
                        end
                    end
                    if (32'(line_d) + 32'(bottom_row) >= LINE_MAX) begin
                        state_d = StLanded;
                    end
                end else begin
                    tick_d = tick_q - TICK_W'(1);
                end
                if (hit_now && popcount == CNT_W'(1)) begin
                    state_d = StCleared;
                end
            end
            StCleared: begin
                if (start_edge) begin
                    state_d  = StMarch;
                    level_d  = level_next;
                    array_d  = '1;
                    offset_d = '0;
                    line_d   = (32'(level_next) < LINE_CAP) ? Y_W'(level_next) : Y_W'(LINE_CAP);
                    dir_d    = DirRight;
                    tick_d   = TICK_W'(RELOAD_FULL);
                end
            end
            StLanded: begin
                if (start_edge) begin
                    state_d  = StMarch;
                    level_d  = 3'd0;
                    array_d  = '1;
                    offset_d = '0;
                    line_d   = '0;
                    dir_d    = DirRight;
                    tick_d   = TICK_W'(RELOAD_FULL);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_36MHz) begin
        if (reset) begin
            state_q    <= StIdle;
            array_q    <= '1;
            line_q     <= '0;
            offset_q   <= '0;
            dir_q      <= DirRight;
            tick_q     <= TICK_W'(RELOAD_FULL);
            level_q    <= 3'd0;
            hit_q      <= 1'b0;
            hit_lock_q <= 1'b0;
            start_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            array_q    <= array_d;
            line_q     <= line_d;
            offset_q   <= offset_d;
            dir_q      <= dir_d;
            tick_q     <= tick_d;
            level_q    <= level_d;
            hit_q      <= hit_d;
            hit_lock_q <= hit_lock_d;
            start_q    <= start;
        end
    end

    assign hit             = hit_q;
    assign invaders_array  = array_q;
    assign invaders_line   = line_q;
    assign invaders_offset = offset_q;
    assign alive_count     = popcount;
    assign wave_clear      = (state_q == StCleared);
    assign landed          = (state_q == StLanded);
    assign level           = level_q;

endmodule

// File: tb/tb_invaders_formation.sv
// Directed bench for invaders_formation with small timing parameters (one step per 25 clocks).
module tb_invaders_formation;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [4:0]  bullet_x = '0;
    logic [3:0]  bullet_y = '0;
    logic        bullet_flying = 1'b0;
    logic        hit;
    logic [19:0] invaders_array;
    logic [3:0]  invaders_line;
    logic [4:0]  invaders_offset;
    logic [4:0]  alive_count;
    logic        wave_clear;
    logic        landed;
    logic [2:0]  level;

    int errors = 0;
    int checks = 0;

    invaders_formation #(
        .COLS       (10),
        .ROWS       (2),
        .X_W        (5),
        .Y_W        (4),
        .FIELD_COLS (32),
        .LINE_MAX   (3),
        .STEP_BASE  (4),
        .STEP_INC   (1)
    ) dut (
        .clk_36MHz       (clk),
        .reset           (reset),
        .start           (start),
        .bullet_x        (bullet_x),
        .bullet_y        (bullet_y),
        .bullet_flying   (bullet_flying),
        .hit             (hit),
        .invaders_array  (invaders_array),
        .invaders_line   (invaders_line),
        .invaders_offset (invaders_offset),
        .alive_count     (alive_count),
        .wave_clear      (wave_clear),
        .landed          (landed),
        .level           (level)
    );

    always #5 clk = ~clk;

    task automatic cycle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        cycle(2);
        reset = 1'b0;
        checks++; if (invaders_array !== 20'hFFFFF) begin errors++;
            $display("FAIL reset_array: got %h expected fffff", invaders_array); end
        checks++; if (invaders_line !== 4'd0) begin errors++;
            $display("FAIL reset_line: got %0d expected 0", invaders_line); end
        checks++; if (invaders_offset !== 5'd0) begin errors++;
            $display("FAIL reset_offset: got %0d expected 0", invaders_offset); end
        checks++; if ({hit, wave_clear, landed} !== 3'b000) begin errors++;
            $display("FAIL reset_flags: got %b expected 000", {hit, wave_clear, landed}); end
        checks++; if (level !== 3'd0 || alive_count !== 5'd20) begin errors++;
            $display("FAIL reset_level_alive: got %0d/%0d expected 0/20", level, alive_count); end
        cycle(40);
        checks++; if (invaders_offset !== 5'd0) begin errors++;
            $display("FAIL idle_static: got offset %0d expected 0", invaders_offset); end
    endtask

    // Start edge E0; a second start edge at E10 must not reload; first step at E25.
    task automatic test_first_step();
        start = 1'b1; cycle(1);
        start = 1'b0; cycle(9);
        start = 1'b1; cycle(1);
        start = 1'b0; cycle(14);
        checks++; if (invaders_offset !== 5'd0) begin errors++;
            $display("FAIL pre_step: got offset %0d expected 0", invaders_offset); end
        cycle(1);
        checks++; if (invaders_offset !== 5'd1 || invaders_line !== 4'd0) begin errors++;
            $display("FAIL first_step: got off %0d line %0d expected 1 0",
                     invaders_offset, invaders_line); end
    endtask

    task automatic test_march_right();
        cycle(25 * 21);
        checks++; if (invaders_offset !== 5'd22 || invaders_line !== 4'd0) begin errors++;
            $display("FAIL march_22: got off %0d line %0d expected 22 0",
                     invaders_offset, invaders_line); end
        cycle(25);
        checks++; if (invaders_offset !== 5'd22 || invaders_line !== 4'd1) begin errors++;
            $display("FAIL step_down: got off %0d line %0d expected 22 1",
                     invaders_offset, invaders_line); end
        cycle(25);
        checks++; if (invaders_offset !== 5'd21 || invaders_line !== 4'd1) begin errors++;
            $display("FAIL march_left: got off %0d line %0d expected 21 1",
                     invaders_offset, invaders_line); end
    endtask

    // Formation at offset 21, line 1, just stepped: 24 quiet clocks before the next step.
    task automatic test_hit();
        int extra;
        bullet_x = 5'd24; bullet_y = 4'd2; bullet_flying = 1'b1;
        cycle(1);
        checks++; if (hit !== 1'b1) begin errors++;
            $display("FAIL hit_pulse: got %b expected 1", hit); end
        checks++; if (invaders_array[13] !== 1'b0 || alive_count !== 5'd19) begin errors++;
            $display("FAIL hit_bit13: got bit %b alive %0d expected 0 19",
                     invaders_array[13], alive_count); end
        extra = 0;
        for (int i = 0; i < 5; i++) begin
            cycle(1);
            if (hit === 1'b1) extra++;
        end
        checks++; if (extra !== 0) begin errors++;
            $display("FAIL hit_lock: got %0d extra hits expected 0", extra); end
        bullet_flying = 1'b0; cycle(1);
        bullet_flying = 1'b1; cycle(2);
        checks++; if (hit !== 1'b0 || alive_count !== 5'd19) begin errors++;
            $display("FAIL dead_bit: got hit %b alive %0d expected 0 19", hit, alive_count); end
        bullet_x = 5'd0; bullet_y = 4'd2; cycle(2);
        checks++; if (alive_count !== 5'd19) begin errors++;
            $display("FAIL miss_borrow: got alive %0d expected 19", alive_count); end
        bullet_x = 5'd24; bullet_y = 4'd3; cycle(2);
        checks++; if (alive_count !== 5'd19) begin errors++;
            $display("FAIL miss_row: got alive %0d expected 19", alive_count); end
        bullet_x = 5'd31; bullet_y = 4'd2; cycle(2);
        checks++; if (alive_count !== 5'd19) begin errors++;
            $display("FAIL miss_col: got alive %0d expected 19", alive_count); end
        bullet_flying = 1'b0;
        cycle(1);
    endtask

    task automatic test_wave_clear();
        int hits;
        reset = 1'b1; cycle(2);
        reset = 1'b0;
        start = 1'b1; cycle(1);
        start = 1'b0;
        hits = 0;
        for (int c = 0; c < 10; c++) begin
            bullet_x = 5'(c); bullet_y = 4'd0; bullet_flying = 1'b1; cycle(1);
            if (hit === 1'b1) hits++;
            bullet_flying = 1'b0; cycle(1);
        end
        checks++; if (alive_count !== 5'd10 || invaders_array !== 20'hFFC00) begin errors++;
            $display("FAIL row0_killed: got alive %0d array %h expected 10 ffc00",
                     alive_count, invaders_array); end
        cycle(5);
        checks++; if (invaders_offset !== 5'd1) begin errors++;
            $display("FAIL kill_step: got offset %0d expected 1", invaders_offset); end
        for (int c = 0; c < 10; c++) begin
            bullet_x = 5'(c + 1); bullet_y = 4'd1; bullet_flying = 1'b1; cycle(1);
            if (hit === 1'b1) hits++;
            bullet_flying = 1'b0; cycle(1);
        end
        checks++; if (hits !== 20) begin errors++;
            $display("FAIL kill_hits: got %0d hit pulses expected 20", hits); end
        checks++; if (wave_clear !== 1'b1 || alive_count !== 5'd0 || invaders_array !== '0) begin
            errors++;
            $display("FAIL cleared: got wc %b alive %0d array %h expected 1 0 00000",
                     wave_clear, alive_count, invaders_array); end
        cycle(60);
        checks++; if (invaders_offset !== 5'd1 || wave_clear !== 1'b1) begin errors++;
            $display("FAIL cleared_frozen: got off %0d wc %b expected 1 1",
                     invaders_offset, wave_clear); end
        start = 1'b1; cycle(1);
        start = 1'b0;
        checks++; if (level !== 3'd1 || invaders_line !== 4'd1 || wave_clear !== 1'b0) begin
            errors++;
            $display("FAIL next_wave: got lvl %0d line %0d wc %b expected 1 1 0",
                     level, invaders_line, wave_clear); end
        checks++; if (invaders_array !== 20'hFFFFF || invaders_offset !== 5'd0) begin errors++;
            $display("FAIL refill: got array %h off %0d expected fffff 0",
                     invaders_array, invaders_offset); end
    endtask

    // From line 1 offset 0: 22 steps right, the 23rd steps down to line 2 and lands.
    task automatic test_landing();
        cycle(574);
        checks++; if (landed !== 1'b0 || invaders_line !== 4'd1 || invaders_offset !== 5'd22)
        begin
            errors++;
            $display("FAIL pre_land: got landed %b line %0d off %0d expected 0 1 22",
                     landed, invaders_line, invaders_offset); end
        cycle(1);
        checks++; if (landed !== 1'b1 || invaders_line !== 4'd2) begin errors++;
            $display("FAIL land: got landed %b line %0d expected 1 2", landed, invaders_line); end
        cycle(50);
        checks++; if (invaders_offset !== 5'd22 || invaders_line !== 4'd2) begin errors++;
            $display("FAIL land_frozen: got off %0d line %0d expected 22 2",
                     invaders_offset, invaders_line); end
        start = 1'b1; cycle(1);
        start = 1'b0;
        checks++; if (level !== 3'd0 || invaders_line !== 4'd0 || landed !== 1'b0) begin
            errors++;
            $display("FAIL land_restart: got lvl %0d line %0d landed %b expected 0 0 0",
                     level, invaders_line, landed); end
    endtask

    task automatic test_reset_mid();
        cycle(3);
        bullet_x = 5'd0; bullet_y = 4'd0; bullet_flying = 1'b1; reset = 1'b1;
        cycle(1);
        checks++; if (hit !== 1'b0 || alive_count !== 5'd20 || invaders_array !== 20'hFFFFF)
        begin
            errors++;
            $display("FAIL mid_reset: got hit %b alive %0d array %h expected 0 20 fffff",
                     hit, alive_count, invaders_array); end
        reset = 1'b0;
        cycle(30);
        checks++; if (alive_count !== 5'd20 || invaders_offset !== 5'd0) begin errors++;
            $display("FAIL post_reset_idle: got alive %0d off %0d expected 20 0",
                     alive_count, invaders_offset); end
        bullet_flying = 1'b0;
    endtask

    initial begin
        test_reset();
        test_first_step();
        test_march_right();
        test_hit();
        test_wave_clear();
        test_landing();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
